// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter with a pending-write scoreboard.
// Two writeback requesters (A = ALU, B = load unit) share one register-file
// write port. Contention is resolved round-robin on the last granted
// requester. The granted write is registered onto we/wa/wd for one cycle and
// commits at the edge that ends that cycle. A 16-entry pending vector tracks
// registers reserved by issue and not yet written back, for hazard queries.
//
// Handshake: a requester raises valid with stable addr/data and keeps them
// stable until it sees ready=1; a transfer happens at each rising edge where
// valid and ready are both 1. ready is combinational from the valids and the
// round-robin state, is never 1 for both requesters, and is 0 during reset.
module rf_write_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [3:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [3:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic       rsv_valid,
    input  logic [3:0] rsv_addr,
    input  logic [3:0] chk_a,
    input  logic [3:0] chk_b,
    output logic       busy_a,
    output logic       busy_b,
    output logic       we,
    output logic [3:0] wa,
    output logic [7:0] wd,
    output logic [7:0] conflict_cnt
);

    // Identity of the requester granted most recently.
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_state_t;

    rr_state_t   rr_last;
    rr_state_t   rr_next;
    logic        grant_a;
    logic        grant_b;
    logic        contention;
    logic [15:0] pending;
    logic [15:0] pending_next;

    assign contention = a_valid && b_valid;

    // Round-robin state register; reset favours A at the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= RR_B;
        end else begin
            rr_last <= rr_next;
        end
    end

    // Grant decision and round-robin next state; no grant while in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        rr_next = rr_last;
        if (rst) begin
            if (contention) begin
                grant_a = (rr_last == RR_B);
                grant_b = (rr_last == RR_A);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        if (grant_a) begin
            rr_next = RR_A;
        end else if (grant_b) begin
            rr_next = RR_B;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Registered write port: one cycle of we per transfer, addr/data hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we <= 1'b0;
            wa <= 4'd0;
            wd <= 8'd0;
        end else begin
            we <= grant_a || grant_b;
            if (grant_a) begin
                wa <= a_addr;
                wd <= a_data;
            end else if (grant_b) begin
                wa <= b_addr;
                wd <= b_data;
            end
        end
    end

    // Scoreboard update: commit clears, reservation sets; set is applied last so it wins.
    always_comb begin
        pending_next = pending;
        if (we) begin
            pending_next[wa] = 1'b0;
        end
        if (rsv_valid) begin
            pending_next[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 16'd0;
        end else begin
            pending <= pending_next;
        end
    end

    // Hazard queries read the registered vector, no same-edge bypass.
    assign busy_a = pending[chk_a];
    assign busy_b = pending[chk_b];

    // Count contention cycles; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= 8'd0;
        end else if (contention) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. A small register-file model commits
// we/wa/wd at each rising edge so writes can be checked end to end.
module tb_rf_write_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid;
    logic [3:0] a_addr;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [3:0] b_addr;
    logic [7:0] b_data;
    logic       b_ready;
    logic       rsv_valid;
    logic [3:0] rsv_addr;
    logic [3:0] chk_a;
    logic [3:0] chk_b;
    logic       busy_a;
    logic       busy_b;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [7:0] conflict_cnt;

    logic [7:0] rf [16];

    int errors = 0;
    int checks = 0;
    int a_grants;
    int both_ready;

    rf_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .chk_a        (chk_a),
        .chk_b        (chk_b),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .conflict_cnt (conflict_cnt)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model written by the DUT write port.
    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rst = 1'b0;
        a_valid = 1'b0; a_addr = 4'd0; a_data = 8'd0;
        b_valid = 1'b0; b_addr = 4'd0; b_data = 8'd0;
        rsv_valid = 1'b0; rsv_addr = 4'd0;
        chk_a = 4'd0; chk_b = 4'd0;

        // Reset state, ready gated while in reset.
        tick();
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_we", we, 1'b0);
        chk("rst_wa", wa, 4'd0);
        chk("rst_wd", wd, 8'd0);
        chk("rst_cnt", conflict_cnt, 8'd0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        rst = 1'b1;

        // Single write from A to register 3.
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'hAA;
        #1;
        chk("a_only_a_ready", a_ready, 1'b1);
        chk("a_only_b_ready", b_ready, 1'b0);
        tick();
        a_valid = 1'b0;
        chk("a_wr_we", we, 1'b1);
        chk("a_wr_wa", wa, 4'd3);
        chk("a_wr_wd", wd, 8'hAA);
        tick();
        chk("idle_we", we, 1'b0);
        chk("idle_wa_hold", wa, 4'd3);
        chk("idle_wd_hold", wd, 8'hAA);
        chk("rf3", rf[3], 8'hAA);
        chk_b = 4'd3;
        #1;
        chk("nonpending_busy_b", busy_b, 1'b0);

        // Reserve 5, B writes 5, pending clears at the commit edge.
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        tick();
        rsv_valid = 1'b0; chk_a = 4'd5;
        #1;
        chk("rsv5_busy_a", busy_a, 1'b1);
        b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h55;
        #1;
        chk("b_only_b_ready", b_ready, 1'b1);
        chk("b_only_a_ready", a_ready, 1'b0);
        tick();
        b_valid = 1'b0;
        chk("b_wr_wa", wa, 4'd5);
        chk("b5_busy_before_commit", busy_a, 1'b1);
        tick();
        chk("b5_busy_after_commit", busy_a, 1'b0);
        chk("rf5", rf[5], 8'h55);

        // Contention for 4 cycles: last grant was B, so A, B, A, B.
        a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_b_ready", b_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick();
            chk("rr_wa", wa, (i % 2 == 0) ? 4'd1 : 4'd2);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr_cnt4", conflict_cnt, 8'd4);
        tick();
        chk("rf1", rf[1], 8'h11);
        chk("rf2", rf[2], 8'h22);

        // Same destination from both: A first, then B; B's data remains.
        a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h91;
        b_valid = 1'b1; b_addr = 4'd9; b_data = 8'h92;
        #1;
        chk("same_a_first", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("same_b_second", b_ready, 1'b1);
        tick();
        b_valid = 1'b0;
        tick();
        chk("rf9_last_wins", rf[9], 8'h92);
        chk("same_cnt5", conflict_cnt, 8'd5);

        // Reservation of 7 at the edge that commits a write to 7: set wins.
        a_valid = 1'b1; a_addr = 4'd7; a_data = 8'h77;
        tick();
        a_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 4'd7;
        chk("w7_we", we, 1'b1);
        tick();
        rsv_valid = 1'b0; chk_a = 4'd7;
        #1;
        chk("set_wins_busy_a", busy_a, 1'b1);
        chk("rf7", rf[7], 8'h77);

        // Reset during the registered-write cycle discards the write.
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h3C;
        tick();
        a_valid = 1'b0;
        chk("pre_rst_we", we, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_we", we, 1'b0);
        chk("async_rst_wa", wa, 4'd0);
        chk("rst_clears_pending", busy_a, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rf3_kept", rf[3], 8'hAA);
        chk("post_rst_cnt", conflict_cnt, 8'd0);

        // 256 contention cycles: counter wraps, never a double grant.
        a_valid = 1'b1; a_addr = 4'd10; a_data = 8'hA0;
        b_valid = 1'b1; b_addr = 4'd11; b_data = 8'hB0;
        #1;
        chk("resume_a_ready", a_ready, 1'b1);
        a_grants = 0;
        both_ready = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (a_ready) a_grants++;
            if (a_ready && b_ready) both_ready++;
            if (!a_ready && !b_ready) both_ready++;
            tick();
            if (i == 254) chk("cnt_255", conflict_cnt, 8'd255);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("cnt_wrap", conflict_cnt, 8'd0);
        chk("one_grant_each_cycle", both_ready, 0);
        chk("a_grants_half", a_grants, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have these parameters: none; register file depth is fixed at 16 x 8 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_addr  input  4  requester A destination register.
REQ-006 a_data  input  8  requester A write data.
REQ-007 a_ready  output  1  requester A is granted this cycle.
REQ-008 b_valid, b_addr, b_data, b_ready  SHALL mirror REQ-004..007 for requester B (load unit).
REQ-009 rsv_valid  input  1  issue stage reserves a destination register.
REQ-010 rsv_addr  input  4  register being reserved.
REQ-011 chk_a, chk_b  input  4 each  register numbers queried for hazards.
REQ-012 busy_a, busy_b  output  1 each  queried register has an uncommitted write.
REQ-013 we  output  1  write enable to reg_file.
REQ-014 wa  output  4  write address to reg_file.
REQ-015 wd  output  8  write data to reg_file.
REQ-016 conflict_cnt  output  8  count of cycles in which both requesters were valid.

Function
REQ-017 Grant is combinational from the valid inputs and rr_last; at most one of a_ready and b_ready SHALL be 1 in any cycle.
REQ-018 Only one valid requester: that requester SHALL be granted.
REQ-019 Both requesters valid: the requester not equal to rr_last SHALL be granted; the other sees ready=0 and must hold valid, addr, data stable.
REQ-020 rr_last SHALL update to the granted requester on every grant and hold when there is no grant.
REQ-021 Transfer occurs when valid and ready are both 1 at a rising edge; at most one transfer per cycle.
REQ-022 we, wa, wd SHALL be registered: a transfer at edge N drives we=1 with the transfer's addr/data during cycle N+1; with no transfer at edge N, we=0 in cycle N+1 and wa/wd hold their previous values.
REQ-023 Write latency from transfer edge to reg_file commit SHALL be exactly 1 additional edge (the edge ending cycle N+1).
REQ-024 The scoreboard SHALL be a 16-bit pending vector; rsv_valid=1 at an edge sets pending[rsv_addr].
REQ-025 An edge ending a cycle with we=1 SHALL clear pending[wa].
REQ-026 Set and clear of the same register at the same edge: the set SHALL win (pending stays 1).
REQ-027 busy_a = pending[chk_a] and busy_b = pending[chk_b], combinational, with no bypass of same-edge set/clear.
REQ-028 A write to a register that is not pending SHALL still be performed and SHALL leave pending at 0.
REQ-029 conflict_cnt SHALL increment by 1 at each edge where a_valid and b_valid are both 1, wrapping 255 -> 0.
REQ-030 Both requesters targeting the same register SHALL be serialized in grant order; the later write determines the final value.

Reset
REQ-031 While rst=0: we=0, wa=0, wd=0, pending=0, conflict_cnt=0, rr_last=B (so A wins the first contention); a_ready/b_ready SHALL be 0.
REQ-032 Reset assertion mid-transfer SHALL discard any registered write (we forced to 0 immediately); nothing is committed after reset deasserts.
REQ-033 After rst rises, grants SHALL resume on the first rising edge.

Verification
REQ-034 Reset, then a_valid=1, a_addr=3, a_data=AA for one cycle -> a_ready=1 at once; we=1, wa=3, wd=AA in the next cycle; reg_file reads AA from register 3 afterwards.
REQ-035 Both valid for 4 cycles (A: addr 1, data 11; B: addr 2, data 22; each deasserts after its grant, then reasserts) -> grant order A, B, A, B; conflict_cnt=4.
REQ-036 rsv_valid with rsv_addr=5, then chk_a=5 -> busy_a=1; B writes register 5 -> busy_a returns to 0 after the commit edge.
REQ-037 rsv_addr=7 at the same edge where a we=1 cycle with wa=7 ends -> pending[7] stays 1; busy_a=1 with chk_a=7.
REQ-038 Hold both valid for 256 cycles -> conflict_cnt wraps to 0; no cycle has a_ready=b_ready=1.
REQ-039 Grant A at edge N, then rst=0 during cycle N+1 -> we drops to 0 immediately and the target register keeps its old value.
